// File: rtl/pc_fetch_seq.sv
// Instruction fetch sequencer: PC, imem handshake,
// IF/ID output slot with one-entry skid buffer.
module pc_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [1:0]  jump_sel,
  input  logic [31:0] redirect_base,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_target,
  input  logic [31:0] rs_value,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;

  logic        taken;
  logic [31:0] target;
  logic        issue;
  logic        got;
  logic        keep;

  always_comb begin
    taken  = redirect_valid && (jump_sel != 2'b00);
    target = redirect_base;
    unique case (jump_sel)
      2'b01: target = redirect_base + (branch_offset << 2);
      2'b10: target = {redirect_base[31:28], jump_target, 2'b00};
      2'b11: target = {rs_value[31:2], 2'b00};
      default: target = redirect_base;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RUN: begin
        if (issue && !imem_ack) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack)   state_nx = S_RUN;
        else if (taken) state_nx = S_DISCARD;
      end
      S_DISCARD: begin
        if (imem_ack) state_nx = S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  // rst_n gates the issue so the bus is idle while reset is held
  always_comb begin
    issue     = rst_n && (state == S_RUN)
                && !skid_valid && !taken;
    imem_req  = issue || (state != S_RUN);
    imem_addr = (state == S_RUN) ? pc : req_addr;
    got       = imem_ack && imem_req;
    keep      = got && (state != S_DISCARD) && !taken;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      flush      <= 1'b0;
      if_valid   <= 1'b0;
      if_pc      <= 32'h0;
      if_instr   <= 32'h0;
      skid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= 32'h0;
    end else begin
      flush <= taken;
      if (issue) req_addr <= pc;
      if (taken)     pc <= target;
      else if (keep) pc <= pc + 32'd4;
      if (taken) begin
        if_valid   <= 1'b0;
        skid_valid <= 1'b0;
      end else if (keep) begin
        if (!if_valid || !stall) begin
          if_valid <= 1'b1;
          if_pc    <= imem_addr;
          if_instr <= imem_rdata;
        end else begin
          skid_valid <= 1'b1;
          skid_pc    <= imem_addr;
          skid_instr <= imem_rdata;
        end
      end else if (!stall) begin
        if (skid_valid) begin
          if_valid   <= 1'b1;
          if_pc      <= skid_pc;
          if_instr   <= skid_instr;
          skid_valid <= 1'b0;
        end else begin
          if_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: directed scenarios plus
// randomized traffic against a queue-based fetch model.
module tb_pc_fetch_seq;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [1:0]  jump_sel;
  logic [31:0] redirect_base;
  logic [31:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] rs_value;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_fetch_seq #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid),
    .jump_sel(jump_sel),
    .redirect_base(redirect_base),
    .branch_offset(branch_offset),
    .jump_target(jump_target),
    .rs_value(rs_value),
    .stall(stall),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instr(if_instr),
    .flush(flush)
  );

  // Reference: delivered instructions as a FIFO (head is
  // the IF slot, second entry the skid), plus one
  // outstanding-request record.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_pend;
  bit          m_drop;
  bit          m_flush;
  bit          exp_req;
  logic [31:0] exp_addr;
  logic        cap_req;
  logic [31:0] cap_addr;

  function automatic logic [31:0] ref_target();
    logic [31:0] jt32;
    jt32 = {6'b0, jump_target};
    case (jump_sel)
      2'b01: return redirect_base + branch_offset * 4;
      2'b10: return (redirect_base & 32'hF000_0000)
                    | (jt32 * 4);
      default: return rs_value & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc    = RPC;
    m_addr  = RPC;
    m_pend  = 0;
    m_drop  = 0;
    m_flush = 0;
  endtask

  task automatic model_edge(bit tk, logic [31:0] tgt);
    bit got;
    got = imem_ack && exp_req;
    if (!stall && mq.size() > 0) void'(mq.pop_front());
    if (tk) mq.delete();
    else if (got && !m_drop)
      mq.push_back('{exp_addr, imem_rdata});
    if (tk) m_pc = tgt;
    else if (got && !m_drop) m_pc = m_pc + 4;
    if (got) begin
      m_pend = 0;
      m_drop = 0;
    end else if (m_pend) begin
      if (tk) m_drop = 1;
    end else if (exp_req) begin
      m_pend = 1;
      m_addr = exp_addr;
    end
    m_flush = tk;
  endtask

  // One clock: sample the combinational request, step
  // the model at the edge, settle 1 ns past the edge.
  task automatic tick();
    bit          tk;
    logic [31:0] tgt;
    #1;
    cap_req  = imem_req;
    cap_addr = imem_addr;
    tk       = redirect_valid && (jump_sel != 2'b00);
    tgt      = ref_target();
    exp_req  = m_pend || (mq.size() < 2 && !tk);
    exp_addr = m_pend ? m_addr : m_pc;
    @(posedge clk);
    model_edge(tk, tgt);
    #1;
  endtask

  task automatic set_in(bit rv, logic [1:0] js,
                        bit st, bit ak,
                        logic [31:0] rd);
    redirect_valid = rv;
    jump_sel       = js;
    stall          = st;
    imem_ack       = ak;
    imem_rdata     = rd;
  endtask

  task automatic test_reset();
    set_in(0, 2'b00, 0, 0, 32'h0);
    redirect_base = 0;
    branch_offset = 0;
    jump_target   = 0;
    rs_value      = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req); else passed++;
    total++; if (imem_addr !== RPC) $display("FAIL rst_addr got %h exp %h", imem_addr, RPC); else passed++;
    total++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) $display("FAIL rst_slot got %b/%h/%h exp 0", if_valid, if_pc, if_instr); else passed++;
    total++; if (flush !== 1'b0) $display("FAIL rst_flush got %b exp 0", flush); else passed++;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 2'b00, 0, 1, 32'hA000_0000 + i);
      tick();
      total++; if (cap_req !== 1'b1 || cap_addr !== 32'(4 * i)) $display("FAIL zw_req%0d got %b/%h exp 1/%h", i, cap_req, cap_addr, 4 * i); else passed++;
      total++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== 32'hA000_0000 + i) $display("FAIL zw_slot%0d got %b/%h/%h exp 1/%h", i, if_valid, if_pc, if_instr, 4 * i); else passed++;
    end
  endtask

  task automatic test_skid();
    set_in(0, 2'b00, 1, 0, 32'h0);
    tick();
    total++; if (cap_req !== 1'b1 || cap_addr !== 32'h14) $display("FAIL sk_issue got %b/%h exp 1/14", cap_req, cap_addr); else passed++;
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h10) $display("FAIL sk_hold got %b/%h exp 1/10", if_valid, if_pc); else passed++;
    set_in(0, 2'b00, 1, 1, 32'hC0DE_0001);
    tick();
    total++; if (cap_req !== 1'b1 || cap_addr !== 32'h14) $display("FAIL sk_ack got %b/%h exp 1/14", cap_req, cap_addr); else passed++;
    total++; if (if_pc !== 32'h10 || if_valid !== 1'b1) $display("FAIL sk_slot got %b/%h exp 1/10", if_valid, if_pc); else passed++;
    set_in(0, 2'b00, 1, 0, 32'h0);
    tick();
    total++; if (cap_req !== 1'b0) $display("FAIL sk_noreq got %b exp 0", cap_req); else passed++;
    set_in(0, 2'b00, 0, 0, 32'h0);
    tick();
    total++; if (cap_req !== 1'b0) $display("FAIL sk_noreq2 got %b exp 0", cap_req); else passed++;
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h14 || if_instr !== 32'hC0DE_0001) $display("FAIL sk_emerge got %b/%h/%h exp 1/14/c0de0001", if_valid, if_pc, if_instr); else passed++;
    tick();
    total++; if (cap_req !== 1'b1 || cap_addr !== 32'h18 || if_valid !== 1'b0) $display("FAIL sk_next got %b/%h/%b exp 1/18/0", cap_req, cap_addr, if_valid); else passed++;
  endtask

  task automatic test_branch_discard();
    set_in(1, 2'b01, 0, 0, 32'h0);
    redirect_base = 32'h100;
    branch_offset = -32'sd4;
    tick();
    total++; if (cap_req !== 1'b1 || cap_addr !== 32'h18) $display("FAIL br_hold got %b/%h exp 1/18", cap_req, cap_addr); else passed++;
    total++; if (flush !== 1'b1 || if_valid !== 1'b0) $display("FAIL br_flush got %b/%b exp 1/0", flush, if_valid); else passed++;
    set_in(0, 2'b00, 0, 0, 32'h0);
    tick();
    total++; if (cap_req !== 1'b1 || cap_addr !== 32'h18 || flush !== 1'b0) $display("FAIL br_disc got %b/%h/%b exp 1/18/0", cap_req, cap_addr, flush); else passed++;
    set_in(0, 2'b00, 0, 1, 32'hDEAD_BEEF);
    tick();
    total++; if (if_valid !== 1'b0 || flush !== 1'b0) $display("FAIL br_drop got %b/%b exp 0/0", if_valid, flush); else passed++;
    set_in(0, 2'b00, 0, 1, 32'h1111_0000);
    tick();
    total++; if (cap_req !== 1'b1 || cap_addr !== 32'hF0) $display("FAIL br_target got %b/%h exp 1/f0", cap_req, cap_addr); else passed++;
  endtask

  task automatic test_jumps();
    set_in(1, 2'b10, 0, 0, 32'h0);
    redirect_base = 32'h9000_0010;
    jump_target   = 26'h10;
    tick();
    total++; if (cap_req !== 1'b0 || flush !== 1'b1) $display("FAIL j_redir got %b/%b exp 0/1", cap_req, flush); else passed++;
    set_in(0, 2'b00, 0, 1, 32'h2222_0000);
    tick();
    total++; if (cap_addr !== 32'h9000_0040 || if_pc !== 32'h9000_0040) $display("FAIL j_target got %h/%h exp 90000040", cap_addr, if_pc); else passed++;
    set_in(1, 2'b11, 0, 0, 32'h0);
    rs_value = 32'h203;
    tick();
    set_in(0, 2'b00, 0, 1, 32'h3333_0000);
    tick();
    total++; if (cap_req !== 1'b1 || cap_addr !== 32'h200) $display("FAIL jr_target got %b/%h exp 1/200", cap_req, cap_addr); else passed++;
    set_in(1, 2'b00, 0, 1, 32'h4444_0000);
    tick();
    total++; if (cap_addr !== 32'h204 || flush !== 1'b0 || if_pc !== 32'h204) $display("FAIL sel00 got %h/%b/%h exp 204/0/204", cap_addr, flush, if_pc); else passed++;
  endtask

  task automatic test_wrap();
    set_in(1, 2'b11, 0, 0, 32'h0);
    rs_value = 32'hFFFF_FFFE;
    tick();
    set_in(0, 2'b00, 0, 1, 32'h5555_0000);
    tick();
    total++; if (cap_addr !== 32'hFFFF_FFFC || if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_top got %h/%h exp fffffffc", cap_addr, if_pc); else passed++;
    tick();
    total++; if (cap_req !== 1'b1 || cap_addr !== 32'h0) $display("FAIL wrap_zero got %b/%h exp 1/0", cap_req, cap_addr); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    set_in(0, 2'b00, 0, 0, 32'h0);
    tick();
    total++; if (cap_req !== 1'b1 || cap_addr !== 32'h4) $display("FAIL mr_pend got %b/%h exp 1/4", cap_req, cap_addr); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || imem_addr !== RPC) $display("FAIL mr_bus got %b/%h exp 0/%h", imem_req, imem_addr, RPC); else passed++;
    total++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || flush !== 1'b0) $display("FAIL mr_slot got %b/%h/%b exp 0/0/0", if_valid, if_pc, flush); else passed++;
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    set_in(0, 2'b00, 0, 1, 32'h6666_0000);
    tick();
    total++; if (cap_req !== 1'b1 || cap_addr !== RPC) $display("FAIL mr_refetch got %b/%h exp 1/%h", cap_req, cap_addr, RPC); else passed++;
    total++; if (if_valid !== 1'b1 || if_instr !== 32'h6666_0000) $display("FAIL mr_data got %b/%h exp 1/66660000", if_valid, if_instr); else passed++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 7) == 0),
             2'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 1),
             $urandom());
      redirect_base = $urandom();
      branch_offset = $urandom();
      jump_target   = 26'($urandom());
      rs_value      = $urandom();
      tick();
      total++; if (cap_req !== exp_req || (exp_req && cap_addr !== exp_addr)) $display("FAIL rnd_req%0d got %b/%h exp %b/%h", i, cap_req, cap_addr, exp_req, exp_addr); else passed++;
      total++; if (if_valid !== (mq.size() > 0)) $display("FAIL rnd_valid%0d got %b exp %b", i, if_valid, mq.size() > 0); else passed++;
      if (mq.size() > 0) begin
        total++; if (if_pc !== mq[0].pc || if_instr !== mq[0].instr) $display("FAIL rnd_slot%0d got %h/%h exp %h/%h", i, if_pc, if_instr, mq[0].pc, mq[0].instr); else passed++;
      end
      total++; if (flush !== m_flush) $display("FAIL rnd_flush%0d got %b exp %b", i, flush, m_flush); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_skid();
    test_branch_discard();
    test_jumps();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
